// File: rtl/pci_target_ctrl.sv
// PCI target-side transaction controller.
// Latches the address phase, claims memory read/write cycles that the
// downstream decoder hits, drives DEVSEL#/TRDY#/STOP# and the AD read path,
// and owns the small target memory behind the claimed address window.
module pci_target_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'd21,
  parameter int          NUM_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  input  logic        hit,
  output logic [31:0] addr_q,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n
);

  localparam int          IW            = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [31:0] LAST_ADDR     = BASE_ADDR + 32'(NUM_WORDS) - 32'd1;
  localparam logic [3:0]  CMD_MEM_READ  = 4'b0110;
  localparam logic [3:0]  CMD_MEM_WRITE = 4'b0111;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    TURN,
    DATA,
    DISC,
    WAIT_IDLE
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cmd, cmd_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] ad_out_nxt;
  logic        ad_oe_nxt;
  logic        devsel_nxt;
  logic        trdy_nxt;
  logic        stop_nxt;
  logic [31:0] mem     [NUM_WORDS];
  logic [31:0] mem_nxt [NUM_WORDS];

  logic          xfer;
  logic [31:0]   addr_inc;
  logic          cur_in_range;
  logic          inc_in_range;
  logic [IW-1:0] cur_idx;
  logic [IW-1:0] inc_idx;

  // A data phase completes only when both initiator and target are ready.
  assign xfer         = !irdy_n && !trdy_n;
  assign addr_inc     = addr_q + 32'd1;
  assign cur_in_range = (addr_q >= BASE_ADDR) && (addr_q <= LAST_ADDR);
  assign inc_in_range = (addr_inc >= BASE_ADDR) && (addr_inc <= LAST_ADDR);
  assign cur_idx      = IW'(addr_q - BASE_ADDR);
  assign inc_idx      = IW'(addr_inc - BASE_ADDR);

  // State, bus outputs and memory all update together on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cmd      <= 4'd0;
      addr_q   <= 32'd0;
      ad_out   <= 32'd0;
      ad_oe    <= 1'b0;
      devsel_n <= 1'b1;
      trdy_n   <= 1'b1;
      stop_n   <= 1'b1;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else begin
      state    <= state_nxt;
      cmd      <= cmd_nxt;
      addr_q   <= addr_nxt;
      ad_out   <= ad_out_nxt;
      ad_oe    <= ad_oe_nxt;
      devsel_n <= devsel_nxt;
      trdy_n   <= trdy_nxt;
      stop_n   <= stop_nxt;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem[i] <= mem_nxt[i];
      end
    end
  end

  // Transaction sequencing: every register holds unless the current state moves it.
  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd;
    addr_nxt   = addr_q;
    ad_out_nxt = ad_out;
    ad_oe_nxt  = ad_oe;
    devsel_nxt = devsel_n;
    trdy_nxt   = trdy_n;
    stop_nxt   = stop_n;
    for (int i = 0; i < NUM_WORDS; i++) begin
      mem_nxt[i] = mem[i];
    end

    case (state)
      IDLE: begin
        if (!frame_n) begin
          addr_nxt  = ad_in;
          cmd_nxt   = cbe_n;
          state_nxt = DECODE;
        end
      end

      DECODE: begin
        if (hit && (cmd == CMD_MEM_WRITE)) begin
          devsel_nxt = 1'b0;
          trdy_nxt   = 1'b0;
          state_nxt  = DATA;
        end else if (hit && (cmd == CMD_MEM_READ)) begin
          devsel_nxt = 1'b0;
          state_nxt  = TURN;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end

      TURN: begin
        ad_oe_nxt  = 1'b1;
        ad_out_nxt = cur_in_range ? mem[cur_idx] : 32'd0;
        trdy_nxt   = 1'b0;
        state_nxt  = DATA;
      end

      DATA: begin
        if (xfer) begin
          // The address advances on every completed phase so bursts walk the window.
          addr_nxt = addr_inc;
          if ((cmd == CMD_MEM_WRITE) && cur_in_range) begin
            for (int b = 0; b < 4; b++) begin
              if (!cbe_n[b]) begin
                mem_nxt[cur_idx][8*b +: 8] = ad_in[8*b +: 8];
              end
            end
          end
          if ((cmd == CMD_MEM_READ) && inc_in_range) begin
            ad_out_nxt = mem[inc_idx];
          end
          if (frame_n) begin
            devsel_nxt = 1'b1;
            trdy_nxt   = 1'b1;
            ad_oe_nxt  = 1'b0;
            state_nxt  = IDLE;
          end else if (addr_q == LAST_ADDR) begin
            // The next phase would fall outside the window, so disconnect.
            trdy_nxt  = 1'b1;
            stop_nxt  = 1'b0;
            ad_oe_nxt = 1'b0;
            state_nxt = DISC;
          end
        end
      end

      DISC: begin
        if (frame_n) begin
          devsel_nxt = 1'b1;
          stop_nxt   = 1'b1;
          trdy_nxt   = 1'b1;
          state_nxt  = WAIT_IDLE;
        end
      end

      WAIT_IDLE: begin
        if (frame_n && irdy_n) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Self-checking bench for pci_target_ctrl.
// A transaction-level initiator drives PCI cycles and, for every clock it
// drives, pushes the bus state the target should show after that edge.
// A monitor pops one expectation per clock and compares.
module tb_pci_target_ctrl;

  localparam logic [31:0] BASE  = 32'd21;
  localparam logic [31:0] TOP   = 32'd24;
  localparam int          NW    = 4;
  localparam logic [3:0]  MRD   = 4'b0110;
  localparam logic [3:0]  MWR   = 4'b0111;

  typedef struct packed {
    logic        devsel_n;
    logic        trdy_n;
    logic        stop_n;
    logic        ad_oe;
    logic [31:0] addr_q;
    logic        chk_ad;
    logic [31:0] ad_out;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_n;
  logic        irdy_n;
  logic [3:0]  cbe_n;
  logic [31:0] ad_in;
  logic        hit;
  logic [31:0] addr_q;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic        devsel_n;
  logic        trdy_n;
  logic        stop_n;

  int          checks = 0;
  int          fails  = 0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [NW];
  logic [31:0] ph_data [8];
  logic [3:0]  ph_be   [8];
  int          ph_wait [8];

  pci_target_ctrl #(.BASE_ADDR(32'd21), .NUM_WORDS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_n  (frame_n),
    .irdy_n   (irdy_n),
    .cbe_n    (cbe_n),
    .ad_in    (ad_in),
    .hit      (hit),
    .addr_q   (addr_q),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .devsel_n (devsel_n),
    .trdy_n   (trdy_n),
    .stop_n   (stop_n)
  );

  always #5 clk = ~clk;

  // Address decoder stand-in: claims exactly the memory window.
  assign hit = (addr_q >= BASE) && (addr_q <= TOP);

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (a <= TOP);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'(a - BASE);
  endfunction

  function automatic exp_t mk(input logic dv, input logic tr, input logic st,
                              input logic oe, input logic [31:0] a,
                              input logic ca, input logic [31:0] d);
    exp_t e;
    e.devsel_n = dv;
    e.trdy_n   = tr;
    e.stop_n   = st;
    e.ad_oe    = oe;
    e.addr_q   = a;
    e.chk_ad   = ca;
    e.ad_out   = d;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  // One bus clock: inputs change on the falling edge, expectation is for after the rising edge.
  task automatic apply_stimulus(input logic f, input logic i, input logic [3:0] c,
                                input logic [31:0] d, input exp_t e);
    @(negedge clk);
    frame_n = f;
    irdy_n  = i;
    cbe_n   = c;
    ad_in   = d;
    exp_q.push_back(e);
  endtask

  task automatic set_phase(input int k, input logic [31:0] d, input logic [3:0] be,
                           input int w);
    ph_data[k] = d;
    ph_be[k]   = be;
    ph_wait[k] = w;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_devsel_n"}, {31'd0, devsel_n}, 32'd1);
    check_output({tag, "_trdy_n"},   {31'd0, trdy_n},   32'd1);
    check_output({tag, "_stop_n"},   {31'd0, stop_n},   32'd1);
    check_output({tag, "_ad_oe"},    {31'd0, ad_oe},    32'd0);
    check_output({tag, "_addr_q"},   addr_q,            32'd0);
    check_output({tag, "_ad_out"},   ad_out,            32'd0);
  endtask

  // Initiator: runs one transaction using ph_* as the data phases.
  // abort_at >= 0 stops driving before that phase, leaving the bus mid-burst.
  task automatic do_txn(input logic [3:0] cmd, input logic [31:0] a, input int nph,
                        input int abort_at);
    logic [31:0] cur;
    logic [31:0] nxt;
    logic [31:0] rd;
    logic        is_rd;
    logic        claimed;
    cur     = a;
    rd      = 32'd0;
    is_rd   = (cmd == MRD);
    claimed = ((cmd == MRD) || (cmd == MWR)) && in_range(a);

    apply_stimulus(1'b0, 1'b1, cmd, a, mk(1, 1, 1, 0, a, 0, 0));

    if (!claimed) begin
      for (int k = 0; k < nph; k++) begin
        apply_stimulus(1'b0, 1'b0, ph_be[k], ph_data[k], mk(1, 1, 1, 0, a, 0, 0));
      end
      apply_stimulus(1'b1, 1'b0, 4'hF, 32'd0, mk(1, 1, 1, 0, a, 0, 0));
      apply_stimulus(1'b1, 1'b1, 4'hF, 32'd0, mk(1, 1, 1, 0, a, 0, 0));
      return;
    end

    if (!is_rd) begin
      apply_stimulus(1'b0, 1'b1, 4'hF, 32'd0, mk(0, 0, 1, 0, a, 0, 0));
    end else begin
      apply_stimulus(1'b0, 1'b1, 4'hF, 32'd0, mk(0, 1, 1, 0, a, 0, 0));
      rd = ref_mem[idx(a)];
      apply_stimulus(1'b0, 1'b1, 4'hF, 32'd0, mk(0, 0, 1, 1, a, 1, rd));
    end

    for (int k = 0; k < nph; k++) begin
      if (k == abort_at) return;
      for (int w = 0; w < ph_wait[k]; w++) begin
        apply_stimulus(1'b0, 1'b1, ph_be[k], ph_data[k],
                       mk(0, 0, 1, is_rd, cur, is_rd, rd));
      end
      if (!is_rd) begin
        for (int b = 0; b < 4; b++) begin
          if (!ph_be[k][b]) ref_mem[idx(cur)][8*b +: 8] = ph_data[k][8*b +: 8];
        end
      end
      nxt = cur + 32'd1;
      if (is_rd && in_range(nxt)) rd = ref_mem[idx(nxt)];
      if (k == nph - 1) begin
        apply_stimulus(1'b1, 1'b0, ph_be[k], ph_data[k], mk(1, 1, 1, 0, nxt, 0, 0));
        apply_stimulus(1'b1, 1'b1, 4'hF, 32'd0, mk(1, 1, 1, 0, nxt, 0, 0));
        return;
      end else if (cur == TOP) begin
        apply_stimulus(1'b0, 1'b0, ph_be[k], ph_data[k], mk(0, 1, 0, 0, nxt, 0, 0));
        for (int h = 0; h < ph_wait[k+1] % 3; h++) begin
          apply_stimulus(1'b0, 1'b0, ph_be[k+1], ph_data[k+1], mk(0, 1, 0, 0, nxt, 0, 0));
        end
        apply_stimulus(1'b1, 1'b0, ph_be[k+1], ph_data[k+1], mk(1, 1, 1, 0, nxt, 0, 0));
        apply_stimulus(1'b1, 1'b1, 4'hF, 32'd0, mk(1, 1, 1, 0, nxt, 0, 0));
        return;
      end else begin
        apply_stimulus(1'b0, 1'b0, ph_be[k], ph_data[k],
                       mk(0, 0, 1, is_rd, nxt, is_rd, rd));
        cur = nxt;
      end
    end
  endtask

  // Monitor: after each rising edge, compare against the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("devsel_n", {31'd0, devsel_n}, {31'd0, e.devsel_n});
        check_output("trdy_n",   {31'd0, trdy_n},   {31'd0, e.trdy_n});
        check_output("stop_n",   {31'd0, stop_n},   {31'd0, e.stop_n});
        check_output("ad_oe",    {31'd0, ad_oe},    {31'd0, e.ad_oe});
        check_output("addr_q",   addr_q,            e.addr_q);
        if (e.chk_ad) check_output("ad_out", ad_out, e.ad_out);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0]  rcmd;
    logic [31:0] raddr;
    int          r;
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'd0;
    for (int k = 0; k < 8; k++) set_phase(k, 32'd0, 4'h0, 0);
    rst_n   = 1'b0;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    cbe_n   = 4'hF;
    ad_in   = 32'd0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single write 22");
    set_phase(0, 32'hDEADBEEF, 4'h0, 0);
    do_txn(MWR, 32'd22, 1, -1);

    $display("[TB] single read 22");
    do_txn(MRD, 32'd22, 1, -1);

    $display("[TB] unclaimed write 26");
    do_txn(MWR, 32'd26, 2, -1);

    $display("[TB] burst write from 23 crossing the top");
    set_phase(0, 32'd1, 4'h0, 0);
    set_phase(1, 32'd2, 4'h0, 0);
    set_phase(2, 32'd3, 4'h0, 0);
    do_txn(MWR, 32'd23, 3, -1);
    set_phase(0, 32'd0, 4'h0, 0);
    set_phase(1, 32'd0, 4'h0, 0);
    do_txn(MRD, 32'd23, 2, -1);

    $display("[TB] read 21 with initiator wait states");
    set_phase(0, 32'd0, 4'h0, 2);
    do_txn(MRD, 32'd21, 1, -1);

    $display("[TB] partial byte write 21 then reset mid-burst");
    set_phase(0, 32'h12345678, 4'b1100, 0);
    do_txn(MWR, 32'd21, 1, -1);
    set_phase(0, 32'd0, 4'h0, 0);
    do_txn(MRD, 32'd21, 1, -1);
    set_phase(0, 32'hCAFEF00D, 4'h0, 0);
    set_phase(1, 32'h0BADF00D, 4'h0, 0);
    set_phase(2, 32'h55AA55AA, 4'h0, 0);
    do_txn(MWR, 32'd21, 3, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    for (int i = 0; i < NW; i++) ref_mem[i] = 32'd0;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_phase(0, 32'd0, 4'h0, 0);
    set_phase(1, 32'd0, 4'h0, 0);
    do_txn(MRD, 32'd21, 2, -1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 150; n++) begin
      r     = $urandom_range(0, 9);
      rcmd  = 4'($urandom_range(0, 15));
      if (r < 4) rcmd = MRD;
      else if (r < 8) rcmd = MWR;
      raddr = 32'($urandom_range(19, 26));
      for (int k = 0; k < 8; k++) begin
        set_phase(k, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
      end
      do_txn(rcmd, raddr, $urandom_range(1, 5), -1);
    end

    repeat (3) @(posedge clk);
    #2;
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
